// File: rtl/invz_bus_pkg.sv
// invz_bus_pkg: shared state type and limits for the inverting tristate bus driver
package invz_bus_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    localparam int TURN_W   = 4;
    localparam int CH_MAX   = 16;
    localparam int TURN_MAX = 15;

endpackage

// File: rtl/invz_bus_rr_arb.sv
// invz_bus_rr_arb: combinational round-robin picker, searching upward from rr+1 with wrap-around
module invz_bus_rr_arb
    import invz_bus_pkg::*;
#(
    parameter int CH = 4,
    localparam int IW = $clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [IW-1:0] rr,
    output logic [CH-1:0] onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    // Walk candidates farthest-first so the nearest requester after rr is the last write and wins
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = CH; k >= 1; k--) begin
            cand = IW'((int'(rr) + k) % CH);
            if (req[cand]) idx = cand;
        end
        valid  = |req;
        onehot = valid ? (CH'(1) << idx) : '0;
    end

endmodule

// File: rtl/invz_bus_driver.sv
// invz_bus_driver: multi-channel inverting tristate bus driver with round-robin ownership and Z turnaround; keeper option via INVZ_BUS_KEEPER_EN
module invz_bus_driver
    import invz_bus_pkg::*;
#(
    parameter int CH    = 4,
    parameter int WIDTH = 8,
    parameter int TURN  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [CH-1:0]           REQ,
    input  logic [CH*WIDTH-1:0]     I,
    output logic [CH-1:0]           GNT,
    output logic [WIDTH-1:0]        ZN,
    output logic                    BUSY,
    output logic [$clog2(CH)-1:0]   OWNER,
    inout  wire                     VDD,
    inout  wire                     VSS
);

    localparam int OW = $clog2(CH);

    state_t            state, state_nx;
    logic [TURN_W-1:0] cnt, cnt_nx;
    logic [OW-1:0]     rr, rr_nx, owner_nx, win_idx;
    logic [CH-1:0]     gnt_nx, win_oh;
    logic              win_v, grab;
    logic [WIDTH-1:0]  slice [CH];
    logic [WIDTH-1:0]  drv;
    wire               unused_supply = VDD ^ VSS;

    for (genvar k = 0; k < CH; k++) begin : g_slice
        assign slice[k] = I[k*WIDTH +: WIDTH];
    end

    invz_bus_rr_arb #(.CH(CH)) u_arb (
        .req    (REQ),
        .rr     (rr),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_v)
    );

    // Arbitration happens only from IDLE or at the last turnaround cycle; an owner is never preempted
    always_comb begin
        state_nx = state;
        gnt_nx   = GNT;
        owner_nx = OWNER;
        rr_nx    = rr;
        cnt_nx   = cnt;
        grab     = (state == IDLE) || (state == invz_bus_pkg::TURN && cnt == TURN_W'(TURN));
        if (grab) begin
            state_nx = win_v ? DRIVE : IDLE;
            cnt_nx   = '0;
            if (win_v) begin
                gnt_nx   = win_oh;
                owner_nx = win_idx;
                rr_nx    = win_idx;
            end
        end else if (state == invz_bus_pkg::TURN) begin
            cnt_nx = cnt + 1'b1;
        end else if (state == DRIVE && !REQ[OWNER]) begin
            state_nx = invz_bus_pkg::TURN;
            gnt_nx   = '0;
            cnt_nx   = TURN_W'(1);
        end
    end

    // State, grant, owner and pointer registers; rr starts at CH-1 so channel 0 has first priority
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            GNT   <= '0;
            OWNER <= '0;
            rr    <= OW'(CH - 1);
            cnt   <= '0;
        end else begin
            state <= state_nx;
            GNT   <= gnt_nx;
            OWNER <= owner_nx;
            rr    <= rr_nx;
            cnt   <= cnt_nx;
        end
    end

    assign BUSY = (state != IDLE);
    assign drv  = ~slice[OWNER];

`ifdef INVZ_BUS_KEEPER_EN
    logic [WIDTH-1:0] keep;

    // Keeper tracks the driven value so the net holds it instead of floating
    always_ff @(posedge CLK) begin
        if (RST) keep <= '0;
        else if (state == DRIVE) keep <= drv;
    end

    assign ZN = (|GNT) ? drv : keep;
`else
    assign ZN = (|GNT) ? drv : {WIDTH{1'bz}};
`endif

endmodule
